// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N-to-1 channel multiplexer with manual and
// automatic scan channel selection.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   d      - packed channel data, channel i at bits [i*W+W-1 : i*W]
//   sel    - manual channel request
//   load   - in manual mode, capture sel into the channel register
//   mode   - 0 = manual, 1 = scan (step channels every DWELL enabled cycles)
//   en     - clock enable; 0 freezes channel, dwell count and y
//   y      - registered data of the channel selected before the edge
//   ch     - current channel register
//   valid  - y was captured on the previous edge
//   wrap   - one-cycle pulse after the scan steps from channel N-1 to 0
module mux_scan_reg #(
  parameter int unsigned W     = 4,
  parameter int unsigned N     = 4,
  parameter int unsigned DWELL = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*W-1:0]         d,
  input  logic [$clog2(N)-1:0]   sel,
  input  logic                   load,
  input  logic                   mode,
  input  logic                   en,
  output logic [W-1:0]           y,
  output logic [$clog2(N)-1:0]   ch,
  output logic                   valid,
  output logic                   wrap
);

  localparam int unsigned SW = $clog2(N);
  // A DWELL of 1 still needs a one-bit counter; it simply never leaves 0.
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);

  logic [SW-1:0] ch_q;
  logic [SW-1:0] ch_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [W-1:0]  sel_data;
  logic          wrap_d;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ch_q == SW'(i)) sel_data = d[i*W +: W];
    end
  end

  always_comb begin
    ch_d   = ch_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (mode) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        // N is a power of two, so the natural overflow is the modulo-N step.
        ch_d   = ch_q + 1'b1;
        wrap_d = (ch_q == CH_LAST);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Leaving scan mode never advances, even at the last dwell cycle.
      cnt_d = '0;
      if (load) ch_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q  <= '0;
      cnt_q <= '0;
      y     <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      valid <= en;
      wrap  <= en & wrap_d;
      if (en) begin
        y     <= sel_data;
        ch_q  <= ch_d;
        cnt_q <= cnt_d;
      end
    end
  end

  assign ch = ch_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Testbench for mux_scan_reg: two instances (DWELL=4 and DWELL=1) driven by
// the same inputs and compared against a behavioural model after every edge.
module tb_mux_scan_reg;

  localparam int unsigned W = 4;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] d = '0;
  logic [1:0]     sel = '0;
  logic           load = 1'b0;
  logic           mode = 1'b0;
  logic           en = 1'b0;

  logic [W-1:0]   y0, y1;
  logic [1:0]     ch0, ch1;
  logic           valid0, valid1, wrap0, wrap1;

  mux_scan_reg #(.W(W), .N(N), .DWELL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .d(d), .sel(sel), .load(load), .mode(mode),
    .en(en), .y(y0), .ch(ch0), .valid(valid0), .wrap(wrap0)
  );

  mux_scan_reg #(.W(W), .N(N), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .d(d), .sel(sel), .load(load), .mode(mode),
    .en(en), .y(y1), .ch(ch1), .valid(valid1), .wrap(wrap1)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state, one slot per instance.
  int dw[2] = '{4, 1};
  int m_ch[2], m_cnt[2], m_y[2];
  bit m_valid[2], m_wrap[2];
  int chan[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic apply_chan();
    for (int i = 0; i < N; i++) d[i*W +: W] = chan[i][W-1:0];
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ch[k] = 0; m_cnt[k] = 0; m_y[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      m_wrap[k]  = 0;
      m_valid[k] = en;
      if (en) begin
        m_y[k] = chan[m_ch[k]] % (1 << W);
        if (mode) begin
          if (m_cnt[k] == dw[k] - 1) begin
            m_cnt[k]  = 0;
            m_wrap[k] = (m_ch[k] == N - 1);
            m_ch[k]   = (m_ch[k] + 1) % N;
          end else begin
            m_cnt[k]++;
          end
        end else begin
          m_cnt[k] = 0;
          if (load) m_ch[k] = int'(sel);
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_y4"},     32'(y0),     32'(m_y[0]));
    check({tag, "_ch4"},    32'(ch0),    32'(m_ch[0]));
    check({tag, "_valid4"}, 32'(valid0), 32'(m_valid[0]));
    check({tag, "_wrap4"},  32'(wrap0),  32'(m_wrap[0]));
    check({tag, "_y1"},     32'(y1),     32'(m_y[1]));
    check({tag, "_ch1"},    32'(ch1),    32'(m_ch[1]));
    check({tag, "_valid1"}, 32'(valid1), 32'(m_valid[1]));
    check({tag, "_wrap1"},  32'(wrap1),  32'(m_wrap[1]));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asserts reset between clock edges, checks the immediate effect, then
  // releases on the falling edge so the next rising edge sees rst_n=1.
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_y"},     32'(y0),     32'h0);
    check({tag, "_ch"},    32'(ch0),    32'h0);
    check({tag, "_valid"}, 32'(valid0), 32'h0);
    check({tag, "_wrap"},  32'(wrap0),  32'h0);
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int wraps;

  initial begin
    chan = '{4'hA, 4'hB, 4'hC, 4'hD};
    apply_chan();
    #1;
    model_reset();
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Manual load of channel 2, then observe one-cycle latency to y.
    en = 1'b1; mode = 1'b0; sel = 2'd2; load = 1'b1;
    step("man_load");
    check("man_ch_after_edge1", 32'(ch0), 32'd2);
    load = 1'b0;
    step("man_hold");
    check("man_y_after_edge2", 32'(y0), 32'hC);
    check("man_valid_after_edge2", 32'(valid0), 32'd1);

    // Free-running scan for 20 edges; exactly one wrap pulse.
    pulse_reset("rst_scan");
    mode = 1'b1; wraps = 0;
    for (int i = 0; i < 20; i++) begin
      step("scan20");
      wraps += int'(wrap0);
    end
    check("scan20_wrap_count", 32'(wraps), 32'd1);

    // Freeze at ch=1, cnt=2 with en low, then resume.
    pulse_reset("rst_freeze");
    for (int i = 0; i < 6; i++) step("to_ch1_cnt2");
    en = 1'b0;
    for (int i = 0; i < 5; i++) step("frozen");
    check("frozen_ch", 32'(ch0), 32'd1);
    check("frozen_y", 32'(y0), 32'hB);
    en = 1'b1;
    step("resume1");
    check("resume1_ch", 32'(ch0), 32'd1);
    step("resume2");
    check("resume2_ch", 32'(ch0), 32'd2);

    // load is ignored in scan mode.
    pulse_reset("rst_ignload");
    load = 1'b1; sel = 2'd3;
    for (int i = 0; i < 3; i++) step("ignload");
    check("ignload_hold_ch", 32'(ch0), 32'd0);
    step("ignload_adv");
    check("ignload_adv_ch", 32'(ch0), 32'd1);
    load = 1'b0;

    // Leave scan mode exactly at the last dwell cycle: no advance.
    pulse_reset("rst_exit");
    for (int i = 0; i < 11; i++) step("to_ch2_cnt3");
    mode = 1'b0;
    step("exit_scan");
    check("exit_ch", 32'(ch0), 32'd2);
    check("exit_wrap", 32'(wrap0), 32'd0);
    mode = 1'b1;
    for (int i = 0; i < 3; i++) step("reenter");
    check("reenter_ch_hold", 32'(ch0), 32'd2);
    step("reenter_adv");
    check("reenter_ch_adv", 32'(ch0), 32'd3);

    // Asynchronous reset mid-scan at ch=3.
    pulse_reset("rst_mid0");
    for (int i = 0; i < 12; i++) step("to_ch3");
    check("pre_mid_ch", 32'(ch0), 32'd3);
    pulse_reset("rst_mid");

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) chan[c] = int'($urandom_range(0, 15));
      apply_chan();
      sel  = 2'($urandom_range(0, 3));
      load = ($urandom_range(0, 2) == 0);
      mode = ($urandom_range(0, 9) < 7);
      en   = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 59) == 0) pulse_reset("rand_rst");
      else step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_scan_reg.md
MUX_SCAN_REG -- requirements
Module: mux_scan_reg

Interface
REQ-001 Parameter W, default 4: data width per channel, W >= 1.
REQ-002 Parameter N, default 4: channel count, a power of two, N >= 2; SW = log2(N).
REQ-003 Parameter DWELL, default 4: enabled cycles spent on each channel in scan mode, DWELL >= 1.
REQ-004 clk  input  1: single clock; all state changes on rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 d  input  N*W: packed channel data; channel i occupies bits [i*W+W-1 : i*W].
REQ-007 sel  input  SW: manual channel request.
REQ-008 load  input  1: in manual mode, capture sel into the channel register.
REQ-009 mode  input  1: 0 = manual, 1 = scan (automatic channel stepping).
REQ-010 en  input  1: clock enable; 0 freezes all state.
REQ-011 y  output  W: registered selected data.
REQ-012 ch  output  SW: current channel register.
REQ-013 valid  output  1: y holds data captured on the previous edge.
REQ-014 wrap  output  1: one-cycle pulse on scan wrap-around.

Function
REQ-015 Internal state SHALL be channel register ch_q (drives ch) and dwell counter cnt, 0..DWELL-1.
REQ-016 On every edge with en=1, y SHALL load d[ch_q] using the pre-edge ch_q, giving one cycle of latency from ch to y.
REQ-017 valid SHALL be registered as en: 1 after an enabled edge, 0 after a disabled edge.
REQ-018 Manual mode (mode=0, en=1): load=1 SHALL set ch_q to sel; load=0 SHALL hold ch_q; cnt SHALL be cleared to 0.
REQ-019 Scan mode (mode=1, en=1), cnt < DWELL-1: cnt SHALL increment and ch_q SHALL hold.
REQ-020 Scan mode (mode=1, en=1), cnt = DWELL-1: cnt SHALL clear to 0 and ch_q SHALL advance by 1 modulo N.
REQ-021 wrap SHALL be 1 for exactly the one cycle after an edge at which ch_q advances from N-1 to 0; otherwise 0.
REQ-022 load SHALL be ignored while mode=1.
REQ-023 Mode is sampled at each edge: manual->scan starts dwell at cnt=0 on the current ch_q; scan->manual holds ch_q and clears cnt, even if cnt was at DWELL-1 (no advance).
REQ-024 DWELL=1 SHALL advance ch_q on every enabled scan cycle.
REQ-025 en=0 SHALL hold ch_q, cnt and y, force wrap to 0 and clear valid; the scan resumes from the held cnt when en returns to 1.

Reset
REQ-026 rst_n=0 SHALL, without waiting for a clock edge, set ch_q=0, cnt=0, y=0, valid=0, wrap=0.
REQ-027 Reset SHALL release on rst_n rising; the first enabled edge afterwards behaves as REQ-016..REQ-023 from the reset state.

Verification (W=4, N=4, DWELL=4; d: ch0=A, ch1=B, ch2=C, ch3=D hex)
REQ-028 Reset, then en=1, mode=0, sel=2, load=1 for 1 cycle -> ch=2 after edge 1; y=C, valid=1 after edge 2.
REQ-029 Reset, en=1, mode=1 held 20 cycles -> ch steps 0,1,2,3,0 every 4 edges; y follows ch one edge later; wrap=1 for exactly one cycle at the 3->0 step.
REQ-030 Scan at ch=1, cnt=2, then en=0 for 5 cycles -> ch=1, y=B held, valid=0, wrap=0; after en=1, ch advances to 2 after exactly 2 more edges.
REQ-031 mode=1, load=1, sel=3 at ch=0, cnt=0 -> ch stays 0 until the dwell ends, then becomes 1.
REQ-032 mode drops 1->0 on the edge where cnt=3, ch=2 -> ch stays 2, cnt=0, no wrap.
REQ-033 rst_n pulsed low mid-scan between clock edges at ch=3 -> y=0, ch=0, valid=0 immediately, before any edge.
